mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 data selector between four requesters and drives a registered, valid/ready output channel. It chooses which input the selector passes, captures the chosen beat into an output register, and holds that value until the consumer accepts it. The block sits between four producer blocks and a single downstream consumer. It replaces a free-running select line with a fair, handshaken scheduler.

Parameters:
DW, 4, data width of each input and of out.
MAX_BURST, 4, maximum consecutive beats one requester may hold the selector while others wait; legal range 1..15.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
req  input  4  req[i] high = requester i has a valid beat on its data input; bit 0 maps to in1, bit 3 to in4.
in1, in2, in3, in4  input  DW each  requester data.
out_ready  input  1  consumer accepts out this cycle when out_valid is also high.
gnt  output  4  one-hot, combinational; gnt[i] high in the cycle whose rising edge captures that requester's data; requester i may change data or drop req after that edge.
select  output  2  registered index of the requester currently owning out (00 = in1 … 11 = in4).
out  output  DW  registered captured data.
out_valid  output  1  registered; out holds an unaccepted beat.
busy  output  1  high in state SERVE.

Behaviour:
- Reset: when rst_n is low at a clock edge, the following are cleared at that edge: state = IDLE, out_valid = 0, out = 0, select = 00, rr pointer ptr = 0, beat_cnt = 0. gnt is 0 while rst_n is low.
- Reset mid-transfer drops the pending beat. There is no completion or flush.
- Pick function: pick(p) = first i in the order p, p+1, p+2, p+3 (mod 4) with req[i] = 1.
- load is an internal strobe. When load is high, out <= data[nxt], select <= nxt, out_valid <= 1, and gnt = onehot(nxt).
- State IDLE:
  - out_valid = 0 and busy = 0.
  - If any req bit is high: nxt = pick(ptr), load, beat_cnt <= 1, go to SERVE.
  - Latency: req seen at edge k gives out_valid = 1 after edge k.
- State SERVE:
  - If out_ready = 0: hold out, select and out_valid stable; gnt = 0. out must not change while out_valid = 1 and out_ready = 0.
  - If out_ready = 1, the beat is accepted. Apply the first matching rule, in this order:
  - a) Continue: req[select] = 1 and beat_cnt < MAX_BURST. nxt = select, load, beat_cnt++.
  - b) Switch: another req bit is high. nxt = pick(select+1), load, beat_cnt <= 1, ptr <= select+1.
  - c) Burst exhausted with only the owner requesting: nxt = select, load, beat_cnt <= 1, ptr <= select+1.
  - d) Otherwise: out_valid <= 0, ptr <= select+1, go to IDLE.
- Throughput: one beat per cycle when out_ready is held high. There is no bubble on a burst continue or on a switch.
- req[i] arriving in the same cycle as an accept counts in that cycle's decision.
- req is sampled only when load can occur; a req dropped while the output is stalled is ignored.
- All index arithmetic is 2-bit modulo 4.
- beat_cnt is 4 bits and never exceeds MAX_BURST.
- gnt is never multi-hot. gnt is 0 whenever load is 0.

Test Plan:
1. Reset then a single requester: rst_n low 2 cycles; req = 0001, in1 = 4'hA, out_ready = 1. gnt = 0001 in the first cycle; next cycle out = A, select = 00, out_valid = 1. Drop req: out_valid = 0 one cycle after the accept.
2. Round-robin fairness, MAX_BURST = 1: req = 1111 held, in1..in4 = 1, 2, 3, 4, out_ready = 1. out sequence is 1, 2, 3, 4, 1, … and select is 00, 01, 10, 11, 00, with one beat per cycle.
3. Burst limit, MAX_BURST = 4: req = 0101 held. Four beats go to select = 00, then four to 10, then back to 00. gnt is never 0000 between beats while out_ready = 1.
4. Backpressure: req = 0010, in2 = 7, out_ready = 0 for 5 cycles. out = 7, out_valid = 1 and select = 01 stay stable, and gnt = 0000 throughout. Raise out_ready: gnt = 0010 in that cycle and the next beat loads.
5. Sole requester past the limit, MAX_BURST = 2: req = 1000 only. Beats continue back to back with no bubble. ptr is updated, so a req = 0001 raised later wins over in4 when both are pending.
6. Reset mid-burst: req = 1111 streaming; pull rst_n low for 1 cycle. At the next edge out_valid = 0, out = 0, select = 00. With req still 1111 afterwards, the first grant after reset is gnt = 0001.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between four producers, the round-robin arbiter and one consumer.
// The slave modport is the arbiter's view; the master modport is the producers/consumer side.
interface mux_rr_arbiter_if #(
    parameter int DW = 4
);
    logic [3:0]    req;
    logic [DW-1:0] in1;
    logic [DW-1:0] in2;
    logic [DW-1:0] in3;
    logic [DW-1:0] in4;
    logic          out_ready;
    logic [3:0]    gnt;
    logic [1:0]    select;
    logic [DW-1:0] out;
    logic          out_valid;
    logic          busy;

    modport slave (
        input  req, in1, in2, in3, in4, out_ready,
        output gnt, select, out, out_valid, busy
    );

    modport master (
        output req, in1, in2, in3, in4, out_ready,
        input  gnt, select, out, out_valid, busy
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin scheduler for a shared 4:1 selector feeding a registered valid/ready output.
// One beat per cycle under no backpressure; an owner may hold the selector for MAX_BURST beats.
module mux_rr_arbiter #(
    parameter int DW        = 4,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_rr_arbiter_if.slave   bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_e        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [3:0]    beat_cnt_q, beat_cnt_d;
    logic [1:0]    select_q, select_d;
    logic [DW-1:0] out_q, out_d;
    logic          out_valid_q, out_valid_d;

    logic          load;
    logic [1:0]    nxt;
    logic [3:0]    owner_oh;
    logic [DW-1:0] data [4];

    // First requester at or after p, scanning p, p+1, p+2, p+3 modulo 4.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        pick = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    assign data[0]  = bus.in1;
    assign data[1]  = bus.in2;
    assign data[2]  = bus.in3;
    assign data[3]  = bus.in4;
    assign owner_oh = 4'b0001 << select_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        nxt         = select_q;

        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    nxt        = pick(bus.req, ptr_q);
                    load       = 1'b1;
                    beat_cnt_d = 4'd1;
                    state_d    = SERVE;
                end
            end
            SERVE: begin
                if (bus.out_ready) begin
                    if (bus.req[select_q] && (beat_cnt_q < MAX_CNT)) begin
                        nxt        = select_q;
                        load       = 1'b1;
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end else if (|(bus.req & ~owner_oh)) begin
                        nxt        = pick(bus.req, select_q + 2'd1);
                        load       = 1'b1;
                        beat_cnt_d = 4'd1;
                        ptr_d      = select_q + 2'd1;
                    end else if (bus.req[select_q]) begin
                        nxt        = select_q;
                        load       = 1'b1;
                        beat_cnt_d = 4'd1;
                        ptr_d      = select_q + 2'd1;
                    end else begin
                        out_valid_d = 1'b0;
                        ptr_d       = select_q + 2'd1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // No grant may be issued while reset is asserted.
        if (!rst_n) load = 1'b0;
        if (load) out_valid_d = 1'b1;
    end

    assign out_d    = load ? data[nxt] : out_q;
    assign select_d = load ? nxt : select_q;

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            beat_cnt_q  <= 4'd0;
            select_q    <= 2'd0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            select_q    <= select_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.gnt       = load ? (4'b0001 << nxt) : 4'b0000;
    assign bus.select    = select_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q == SERVE);
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: three instances (MAX_BURST 1, 4, 2) share one stimulus
// and each scenario checks the instance whose burst limit it exercises.
module tb_mux_rr_arbiter;
    localparam int DW = 4;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req;
    logic [DW-1:0] in1, in2, in3, in4;
    logic          out_ready;

    int checks;
    int errors;

    mux_rr_arbiter_if #(.DW(DW)) if_mb1 ();
    mux_rr_arbiter_if #(.DW(DW)) if_mb4 ();
    mux_rr_arbiter_if #(.DW(DW)) if_mb2 ();

    assign if_mb1.req = req;  assign if_mb1.out_ready = out_ready;
    assign if_mb1.in1 = in1;  assign if_mb1.in2 = in2;  assign if_mb1.in3 = in3;  assign if_mb1.in4 = in4;
    assign if_mb4.req = req;  assign if_mb4.out_ready = out_ready;
    assign if_mb4.in1 = in1;  assign if_mb4.in2 = in2;  assign if_mb4.in3 = in3;  assign if_mb4.in4 = in4;
    assign if_mb2.req = req;  assign if_mb2.out_ready = out_ready;
    assign if_mb2.in1 = in1;  assign if_mb2.in2 = in2;  assign if_mb2.in3 = in3;  assign if_mb2.in4 = in4;

    mux_rr_arbiter #(.DW(DW), .MAX_BURST(1)) u_mb1 (.clk(clk), .rst_n(rst_n), .bus(if_mb1));
    mux_rr_arbiter #(.DW(DW), .MAX_BURST(4)) u_mb4 (.clk(clk), .rst_n(rst_n), .bus(if_mb4));
    mux_rr_arbiter #(.DW(DW), .MAX_BURST(2)) u_mb2 (.clk(clk), .rst_n(rst_n), .bus(if_mb2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge; registered outputs are stable 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
        in1 = '0; in2 = '0; in3 = '0; in4 = '0;

        // Reset state, with requests pending to show gnt stays low.
        tick();
        #1;
        check("rst_gnt_low", 32'(if_mb4.gnt), 32'h0);
        tick();
        check("rst_out_valid", 32'(if_mb4.out_valid), 32'h0);
        check("rst_out", 32'(if_mb4.out), 32'h0);
        check("rst_select", 32'(if_mb4.select), 32'h0);
        check("rst_busy", 32'(if_mb4.busy), 32'h0);

        // 1. Single requester then drop.
        rst_n = 1'b1; req = 4'b0001; in1 = 4'hA; out_ready = 1'b1;
        #1;
        check("t1_gnt_first", 32'(if_mb4.gnt), 32'h1);
        tick();
        check("t1_out", 32'(if_mb4.out), 32'hA);
        check("t1_select", 32'(if_mb4.select), 32'h0);
        check("t1_out_valid", 32'(if_mb4.out_valid), 32'h1);
        check("t1_busy", 32'(if_mb4.busy), 32'h1);
        req = 4'b0000;
        #1;
        check("t1_gnt_drop", 32'(if_mb4.gnt), 32'h0);
        tick();
        check("t1_valid_clear", 32'(if_mb4.out_valid), 32'h0);
        check("t1_idle", 32'(if_mb4.busy), 32'h0);
        // Pointer advanced past in1, so in2 beats in1 from IDLE.
        req = 4'b0011;
        #1;
        check("t1_ptr_gnt", 32'(if_mb4.gnt), 32'h2);

        // 2. Round-robin fairness, MAX_BURST = 1.
        do_reset();
        in1 = 4'd1; in2 = 4'd2; in3 = 4'd3; in4 = 4'd4;
        req = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t2_gnt_%0d", k), 32'(if_mb1.gnt), 32'(4'b0001 << (k % 4)));
            tick();
            check($sformatf("t2_out_%0d", k), 32'(if_mb1.out), 32'((k % 4) + 1));
            check($sformatf("t2_sel_%0d", k), 32'(if_mb1.select), 32'(k % 4));
            check($sformatf("t2_valid_%0d", k), 32'(if_mb1.out_valid), 32'h1);
        end

        // 3. Burst limit, MAX_BURST = 4: 4 beats to in1, 4 to in3, then back to in1.
        do_reset();
        in1 = 4'd1; in3 = 4'd3;
        req = 4'b0101; out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            int exp_sel;
            exp_sel = (k >= 4 && k < 8) ? 2 : 0;
            #1;
            check($sformatf("t3_gnt_%0d", k), 32'(if_mb4.gnt), 32'(4'b0001 << exp_sel));
            tick();
            check($sformatf("t3_sel_%0d", k), 32'(if_mb4.select), 32'(exp_sel));
            check($sformatf("t3_out_%0d", k), 32'(if_mb4.out), 32'(exp_sel + 1));
        end

        // 4. Backpressure: output frozen while out_ready is low, even as in2 changes.
        do_reset();
        req = 4'b0010; in2 = 4'd7; out_ready = 1'b0;
        #1;
        check("t4_gnt_load", 32'(if_mb4.gnt), 32'h2);
        tick();
        in2 = 4'd9;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t4_gnt_stall_%0d", k), 32'(if_mb4.gnt), 32'h0);
            tick();
            check($sformatf("t4_out_%0d", k), 32'(if_mb4.out), 32'h7);
            check($sformatf("t4_valid_%0d", k), 32'(if_mb4.out_valid), 32'h1);
            check($sformatf("t4_sel_%0d", k), 32'(if_mb4.select), 32'h1);
        end
        out_ready = 1'b1;
        #1;
        check("t4_gnt_release", 32'(if_mb4.gnt), 32'h2);
        tick();
        check("t4_out_next", 32'(if_mb4.out), 32'h9);

        // 5. Sole requester past the limit, MAX_BURST = 2: no bubbles.
        do_reset();
        req = 4'b1000; in4 = 4'd8; in1 = 4'd1; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t5_gnt_%0d", k), 32'(if_mb2.gnt), 32'h8);
            tick();
            check($sformatf("t5_out_%0d", k), 32'(if_mb2.out), 32'h8);
            check($sformatf("t5_sel_%0d", k), 32'(if_mb2.select), 32'h3);
            check($sformatf("t5_valid_%0d", k), 32'(if_mb2.out_valid), 32'h1);
        end
        req = 4'b0000;
        tick();
        check("t5_idle", 32'(if_mb2.out_valid), 32'h0);
        req = 4'b1001;
        #1;
        check("t5_gnt_in1_wins", 32'(if_mb2.gnt), 32'h1);
        tick();
        check("t5_sel_in1", 32'(if_mb2.select), 32'h0);
        check("t5_out_in1", 32'(if_mb2.out), 32'h1);

        // 6. Reset mid-burst after ownership has moved to in2.
        do_reset();
        in1 = 4'd1; in2 = 4'd2; in3 = 4'd3; in4 = 4'd4;
        req = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check("t6_sel_before", 32'(if_mb4.select), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t6_gnt_in_reset", 32'(if_mb4.gnt), 32'h0);
        tick();
        check("t6_valid_rst", 32'(if_mb4.out_valid), 32'h0);
        check("t6_out_rst", 32'(if_mb4.out), 32'h0);
        check("t6_sel_rst", 32'(if_mb4.select), 32'h0);
        rst_n = 1'b1;
        #1;
        check("t6_gnt_after", 32'(if_mb4.gnt), 32'h1);
        tick();
        check("t6_out_after", 32'(if_mb4.out), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
